// File: rtl/maxnet_input_loader.sv
// maxnet_input_loader: collects N scores from a valid/ready stream into a
// register bank, presents them in parallel to the Maxnet, pulses net_start
// for START_HOLD cycles, then holds the bank until a rising edge of net_done.
// Optional build macro: LOADER_RELU_EN stores negative scores (sign bit set,
// including -0) as all zeros.
module maxnet_input_loader #(
    parameter int unsigned N          = 4,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned START_HOLD = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] data_flat,
    output logic               net_start,
    input  logic               net_done,
    output logic               busy,
    output logic [7:0]         batch_count
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(N - 1);
    localparam logic [3:0]      HoldLast = 4'(START_HOLD - 1);

    typedef enum logic [1:0] {StFill, StStart, StWait} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [3:0]        hold_cnt_q, hold_cnt_d;
    logic              done_q;
    logic [7:0]        batch_count_q, batch_count_d;
    logic [WIDTH-1:0]  bank_q [N];
    logic [WIDTH-1:0]  store_word;
    logic              accept;
    logic              done_rise;

    assign accept    = in_valid && in_ready;
    // Only a fresh rise counts, so a level left over from the last batch is ignored.
    assign done_rise = net_done && !done_q;

`ifdef LOADER_RELU_EN
    // Clamp negative scores to +0 on the way into the bank.
    assign store_word = in_data[WIDTH-1] ? '0 : in_data;
`else
    assign store_word = in_data;
`endif

    // Outputs decode from state only; rst gates in_ready so nothing is taken in reset.
    always_comb begin
        in_ready    = (state_q == StFill) && !rst;
        net_start   = (state_q == StStart);
        busy        = (state_q != StFill);
        batch_count = batch_count_q;
    end

    // Next-state logic for the fill / start / wait sequence.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        hold_cnt_d    = hold_cnt_q;
        batch_count_d = batch_count_q;
        case (state_q)
            StFill: begin
                if (accept) begin
                    if (idx_q == IdxLast) begin
                        idx_d      = '0;
                        hold_cnt_d = '0;
                        state_d    = StStart;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StStart: begin
                if (hold_cnt_q == HoldLast) begin
                    hold_cnt_d = '0;
                    state_d    = StWait;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            StWait: begin
                if (done_rise) begin
                    batch_count_d = batch_count_q + 8'd1;
                    state_d       = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Control state registers; done_q tracks net_done in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StFill;
            idx_q         <= '0;
            hold_cnt_q    <= '0;
            done_q        <= 1'b0;
            batch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            hold_cnt_q    <= hold_cnt_d;
            done_q        <= net_done;
            batch_count_q <= batch_count_d;
        end
    end

    // Score bank; written only on a FILL handshake, so it is frozen while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                bank_q[i] <= '0;
            end
        end else if (accept) begin
            bank_q[idx_q] <= store_word;
        end
    end

    // Flatten the bank, score i at bits [i*WIDTH +: WIDTH].
    always_comb begin
        data_flat = '0;
        for (int i = 0; i < int'(N); i++) begin
            data_flat[i*WIDTH +: WIDTH] = bank_q[i];
        end
    end

endmodule

// File: tb/tb_maxnet_input_loader.sv
// Scoreboard bench for maxnet_input_loader: a batch-level reference model
// predicts each presented bank and each batch count; a negedge monitor pops
// and compares when the DUT starts a batch or bumps batch_count.
module tb_maxnet_input_loader;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int SH  = 1;
    localparam int SH3 = 3;
    localparam int DW  = N * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid, net_done, in_ready, net_start, busy;
    logic [W-1:0]  in_data;
    logic [DW-1:0] data_flat;
    logic [7:0]    batch_count;

    logic          in_valid3, net_done3, in_ready3, net_start3, busy3;
    logic [W-1:0]  in_data3;
    logic [DW-1:0] data_flat3;
    logic [7:0]    batch_count3;

    always #5 clk = ~clk;

    maxnet_input_loader #(.N(N), .WIDTH(W), .START_HOLD(SH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .data_flat(data_flat), .net_start(net_start), .net_done(net_done), .busy(busy),
        .batch_count(batch_count)
    );

    maxnet_input_loader #(.N(N), .WIDTH(W), .START_HOLD(SH3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .data_flat(data_flat3), .net_start(net_start3), .net_done(net_done3), .busy(busy3),
        .batch_count(batch_count3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard queues
    logic [DW-1:0] exp_bank_q[$];
    logic [7:0]    exp_cnt_q[$];

    // Reference model: which phase the loader should be in, words gathered so far
    typedef enum {MFill, MStart, MWait} mphase_e;
    mphase_e      m_phase;
    logic [W-1:0] m_words[$];
    int           m_hold_left;
    logic         m_done_prev;
    int           m_batches;

    function automatic logic [W-1:0] stored(input logic [W-1:0] d);
`ifdef LOADER_RELU_EN
        return d[W-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        m_phase     = MFill;
        m_words.delete();
        m_hold_left = 0;
        m_done_prev = 1'b0;
        m_batches   = 0;
        exp_bank_q.delete();
        exp_cnt_q.delete();
    endtask

    // One clock: drive inputs, check decoded outputs, advance the model.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic dn);
        logic [DW-1:0] b;
        in_valid = v;
        in_data  = d;
        net_done = dn;
        @(negedge clk);
        chk("in_ready", DW'(in_ready), DW'(m_phase == MFill));
        chk("net_start", DW'(net_start), DW'(m_phase == MStart));
        chk("busy", DW'(busy), DW'(m_phase != MFill));
        @(posedge clk);
        #1;
        case (m_phase)
            MFill: begin
                if (v) begin
                    m_words.push_back(stored(d));
                    if (m_words.size() == N) begin
                        for (int i = 0; i < N; i++) b[i*W +: W] = m_words[i];
                        exp_bank_q.push_back(b);
                        m_words.delete();
                        m_phase     = MStart;
                        m_hold_left = SH;
                    end
                end
            end
            MStart: begin
                if (m_hold_left == 1) m_phase = MWait;
                else m_hold_left--;
            end
            MWait: begin
                if (dn && !m_done_prev) begin
                    m_batches++;
                    exp_cnt_q.push_back(8'(m_batches));
                    m_phase = MFill;
                end
            end
            default: ;
        endcase
        m_done_prev = dn;
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b1;
        in_valid  = 1'b0;
        net_done  = 1'b0;
        in_valid3 = 1'b0;
        net_done3 = 1'b0;
        #1;
        chk({tag, "_data_flat"}, data_flat, '0);
        chk({tag, "_net_start"}, DW'(net_start), '0);
        chk({tag, "_in_ready"}, DW'(in_ready), '0);
        chk({tag, "_busy"}, DW'(busy), '0);
        chk({tag, "_batch_count"}, DW'(batch_count), '0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // mode: 0 random, 1 backpressure, 2 sticky done, 3 relu words, 4 basic words
    task automatic run_batch(input int mode);
        int           start_b;
        int           cyc;
        int           wait_cyc;
        logic         v;
        logic         dn;
        logic [W-1:0] d;
        start_b  = m_batches;
        cyc      = 0;
        wait_cyc = 0;
        while (m_batches == start_b && cyc < 400) begin
            v  = 1'b0;
            dn = 1'b0;
            d  = $urandom;
            case (mode)
                0: begin
                    v  = ($urandom % 4) != 0;
                    dn = ($urandom % 2) != 0;
                end
                1: begin
                    if (m_phase == MFill) begin
                        v = cyc[0];
                        if (m_words.size() == 0) d = 32'hDEADBEEF;
                    end else begin
                        v  = 1'b1;
                        d  = 32'hDEADBEEF;
                        dn = (m_phase == MWait) && (wait_cyc == 2);
                    end
                end
                2: begin
                    v  = 1'b1;
                    dn = !(m_phase == MWait && wait_cyc == 4);
                end
                3: begin
                    v = 1'b1;
                    case (m_words.size())
                        0: d = 32'hC0400000;
                        1: d = 32'h80000000;
                        2: d = 32'h3F800000;
                        default: d = 32'h40000000;
                    endcase
                    dn = (m_phase == MWait) && (wait_cyc == 1);
                end
                default: begin
                    v = (m_phase == MFill);
                    case (m_words.size())
                        0: d = 32'h40400000;
                        1: d = 32'h40A00000;
                        2: d = 32'h3F800000;
                        default: d = 32'h40000000;
                    endcase
                    dn = (m_phase == MWait) && (wait_cyc == 1);
                end
            endcase
            cycle(v, d, dn);
            if (m_phase == MWait) wait_cyc++;
            cyc++;
        end
        if (m_batches == start_b) begin
            total++;
            bad++;
            $display("FAIL batch_timeout actual=no_done_exit required=exit_within_400_cycles");
        end
    endtask

    // Monitor: compare presented bank at each start, and every batch_count change.
    logic          prev_start;
    logic [7:0]    prev_cnt;
    logic [DW-1:0] cur_bank;
    logic          have_cur;

    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
            prev_cnt   = 8'd0;
            have_cur   = 1'b0;
        end else begin
            if (net_start && !prev_start) begin
                if (exp_bank_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_bank actual=%h required=no_start", data_flat);
                end else begin
                    cur_bank = exp_bank_q.pop_front();
                    have_cur = 1'b1;
                    chk("sb_bank", data_flat, cur_bank);
                end
            end else if (busy && have_cur) begin
                chk("bank_stable", data_flat, cur_bank);
            end
            if (batch_count != prev_cnt) begin
                if (exp_cnt_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_count actual=%0d required=no_change", batch_count);
                end else begin
                    chk("sb_count", DW'(batch_count), DW'(exp_cnt_q.pop_front()));
                end
            end
            prev_start = net_start;
            prev_cnt   = batch_count;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts;
        logic [DW-1:0] exp3;
        in_valid  = 1'b0;
        in_data   = '0;
        net_done  = 1'b0;
        in_valid3 = 1'b0;
        in_data3  = '0;
        net_done3 = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("reset");

        // Basic batch
        run_batch(4);
        chk("basic_bank", data_flat, 128'h40000000_3F800000_40A00000_40400000);
        chk("basic_count", DW'(batch_count), DW'(1));

        // Backpressure, sticky done, random
        repeat (3) run_batch(1);
        repeat (2) run_batch(2);
        repeat (4) run_batch(0);

        // ReLU words
        run_batch(3);
`ifdef LOADER_RELU_EN
        chk("relu_bank", data_flat, 128'h40000000_3F800000_00000000_00000000);
`else
        chk("relu_bank", data_flat, 128'h40000000_3F800000_80000000_C0400000);
`endif

        // Reset after 2 accepts, then a fresh batch
        cycle(1'b1, $urandom, 1'b0);
        cycle(1'b1, $urandom, 1'b0);
        do_reset("rst_fill");
        run_batch(4);
        chk("post_rst_bank", data_flat, 128'h40000000_3F800000_40A00000_40400000);

        // Reset during WAIT
        for (int k = 0; k < 50 && m_phase != MWait; k++) cycle(1'b1, $urandom, 1'b0);
        cycle(1'b0, '0, 1'b0);
        do_reset("rst_wait");
        run_batch(4);

        // batch_count wrap
        do_reset("rst_wrap");
        repeat (255) run_batch(0);
        chk("count_255", DW'(batch_count), DW'(255));
        run_batch(0);
        chk("count_wrap", DW'(batch_count), '0);

        // START_HOLD=3 instance: hold length and done-during-start
        in_valid3 = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_data3 = 32'h3F800000 + (i << 20);
            exp3[i*W +: W] = 32'h3F800000 + (i << 20);
            @(posedge clk);
            #1;
        end
        in_valid3 = 1'b0;
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (net_start3) starts++;
            if (i == 1) net_done3 = 1'b1;
        end
        chk("hold3_cycles", DW'(starts), DW'(SH3));
        chk("hold3_bank", data_flat3, exp3);
        chk("hold3_still_wait", DW'(busy3), DW'(1));
        chk("hold3_no_count", DW'(batch_count3), '0);
        @(negedge clk);
        net_done3 = 1'b0;
        @(negedge clk);
        net_done3 = 1'b1;
        @(negedge clk);
        chk("hold3_count", DW'(batch_count3), DW'(1));
        chk("hold3_ready", DW'(in_ready3), DW'(1));
        chk("hold3_idle", DW'(busy3), '0);
        net_done3 = 1'b0;

        chk("sb_bank_drained", DW'(exp_bank_q.size()), '0);
        chk("sb_count_drained", DW'(exp_cnt_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maxnet_input_loader.md
# maxnet_input_loader

Upstream feeder for the Maxnet winner-take-all core. It collects a batch of N IEEE-754 single-precision scores over a valid/ready stream into a register bank, presents them in parallel to the Maxnet, and pulses its start. It then holds the operands stable until the Maxnet reports done, after which it accepts the next batch.

## Interface
Parameters:
- N, 4, number of scores per batch (2..16)
- WIDTH, 32, bits per score (IEEE-754 single)
- START_HOLD, 1, cycles net_start stays high (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_data  in  WIDTH  upstream score
- in_ready  out  1  loader can accept a word
- data_flat  out  N*WIDTH  score bank; score i occupies bits [i*WIDTH +: WIDTH]
- net_start  out  1  start to Maxnet
- net_done  in  1  Maxnet done (level; may stay high for many cycles)
- busy  out  1  high in START and WAIT
- batch_count  out  8  completed batches, wraps 255 -> 0

## Operation
- States: FILL, START, WAIT.
- FILL: in_ready=1. On a clock edge with in_valid&&in_ready, bank[idx] <= in_data and idx increments. The accept at idx==N-1 sets idx to 0 and moves the state to START.
- START: net_start=1 for exactly START_HOLD cycles, counted by hold_cnt. The state then moves to WAIT.
- WAIT: leaves on a rising edge of net_done, detected as net_done && !done_q, where done_q is net_done registered every cycle. On that edge: batch_count increments, and the state returns to FILL.
- A net_done level left high from the previous batch does not end WAIT.
- net_done is ignored in FILL and START. done_q still tracks it.
- data_flat changes only on FILL accepts. It is stable throughout START and WAIT.
- busy = (state != FILL).
- in_ready=0 in START and WAIT. in_valid there is ignored and nothing is written.
- Stream words are never dropped. A word is consumed only on the handshake.
- idx width: clog2(N). hold_cnt width: 4 bits.

## Timing
- Reset (async assert): state=FILL, idx=0, bank all 0 (data_flat=0), net_start=0, hold_cnt=0, done_q=0, batch_count=0.
- in_ready is forced 0 while rst is high. Release of rst is synchronous in effect: the first accept can occur on the first rising edge after rst falls.
- in_ready and net_start decode combinationally from state. There are no combinational paths from in_valid or net_done to outputs.
- The Nth accept at edge E gives state=START, so net_start is high from E to E+START_HOLD.
- WAIT is entered at E+START_HOLD.
- The earliest useful done edge is sampled at E+START_HOLD+1. A net_done rise at edge D sets state=FILL and in_ready=1 after D.
- Back-to-back batches are supported: the first word of the next batch can be accepted on the edge after D.
- rst mid-batch, in any state, aborts immediately to reset values. A partial batch is discarded, and net_start falls asynchronously.
- If net_done rises during START, it is not counted. If it is still high on entry to WAIT, WAIT waits for the next rise.

## Configuration
- LOADER_RELU_EN defined: an accepted word with in_data[WIDTH-1]=1 (negative, including -0) is stored as all zeros. Non-negative words are stored verbatim.
- Undefined: every accepted word is stored verbatim. The sign-bit test logic is absent.

## Test plan
- Basic batch: reset, then stream 0x40400000, 0x40A00000, 0x3F800000, 0x40000000 with in_valid held high.
  - After the 4th accept: data_flat=0x40000000_3F800000_40A00000_40400000, net_start high for 1 cycle, busy=1, in_ready=0.
  - A net_done pulse gives batch_count=1 and in_ready=1.
- Backpressure: in_valid toggles 1/0. During START/WAIT, hold in_valid=1 with in_data=0xDEADBEEF.
  - Bank unchanged, no accept counted.
  - After done, 0xDEADBEEF is accepted as score 0 of the next batch.
- Sticky done: hold net_done=1 through the whole batch and into WAIT.
  - Loader stays in WAIT.
  - Drop net_done, then raise it: exit on the rise, batch_count increments by exactly 1.
- START_HOLD=3: net_start is high exactly 3 cycles.
  - A net_done rise during START is ignored; the state stays in WAIT until a later rise.
- Reset mid-operation: assert rst after 2 accepts, and again during WAIT.
  - Outputs return to reset values immediately, net_start=0.
  - A fresh 4-word batch then loads correctly from index 0.
- LOADER_RELU_EN: stream 0xC0400000 (-3.0), 0x80000000 (-0), 0x3F800000, 0x40000000.
  - Defined: scores 0 and 1 are stored as 0x00000000.
  - Undefined: both are stored verbatim.
  - batch_count wraps 255 -> 0 after 256 batches.
